// File: rtl/addsub_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one N-bit add/subtract accumulator.
// Define ADDSUB_SAT_EN to saturate S on two's-complement overflow instead of wrapping.
module addsub_rr_arbiter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         aclr,
   input  logic [1:0]   req,
   input  logic [1:0]   op,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] a1,
   output logic [1:0]   gnt,
   output logic [1:0]   ack,
   output logic         busy,
   output logic [N-1:0] S,
   output logic         carry,
   output logic         overflow,
   output logic         last_id
);

   typedef enum logic [1:0] {IDLE, LATCH, EXEC, DONE} state_t;

   localparam logic [N-1:0] L_MIN = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] L_ONE = {{(N-1){1'b0}}, 1'b1};

   state_t         r_state;
   state_t         w_next;
   logic           w_busy;
   logic           w_win;
   logic           r_w;
   logic [N-1:0]   r_b;
   logic           r_opr;
   logic [1:0]     r_gnt;
   logic [1:0]     r_ack;
   logic [N-1:0]   r_s;
   logic           r_carry;
   logic           r_ovf;
   logic           r_last;
   logic [N:0]     w_res;
   logic           w_ovf;
   logic [N-1:0]   w_s_next;

   // Overflow from the effective addend B' (B for add, -B for subtract); -MIN is MIN itself.
   function automatic logic f_ovf(input logic [N-1:0] s, input logic [N-1:0] b,
                                  input logic [N-1:0] res, input logic add);
      logic [N-1:0] bp;
      bp = add ? b : (~b + L_ONE);
      if (!add && (b == L_MIN))
         return (!s[N-1] && res[N-1]);
      return (s[N-1] == bp[N-1]) && (res[N-1] != s[N-1]);
   endfunction

`ifdef ADDSUB_SAT_EN
   localparam logic [N-1:0] L_MAX = {1'b0, {(N-1){1'b1}}};

   // Overflow direction follows the sign of the accumulator before the operation.
   function automatic logic [N-1:0] f_sat(input logic [N-1:0] res, input logic [N-1:0] s,
                                          input logic ovf);
      if (!ovf)
         return res;
      return s[N-1] ? L_MIN : L_MAX;
   endfunction
`endif

   always_comb begin
      w_win = 1'b0;
      case (req)
         2'b01:   w_win = 1'b0;
         2'b10:   w_win = 1'b1;
         2'b11:   w_win = ~r_last;
         default: w_win = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aclr)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b1;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (|req)
               w_next = LATCH;
         end
         LATCH:   w_next = EXEC;
         EXEC:    w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_res = r_opr ? ({1'b0, r_s} + {1'b0, r_b}) : ({1'b0, r_s} - {1'b0, r_b});
   assign w_ovf = f_ovf(r_s, r_b, w_res[N-1:0], r_opr);

`ifdef ADDSUB_SAT_EN
   assign w_s_next = f_sat(w_res[N-1:0], r_s, w_ovf);
`else
   assign w_s_next = w_res[N-1:0];
`endif

   always_ff @(posedge clk) begin
      if (!aclr) begin
         r_w     <= 1'b0;
         r_b     <= '0;
         r_opr   <= 1'b0;
         r_gnt   <= 2'b00;
         r_ack   <= 2'b00;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_w   <= w_win;
                  r_gnt <= w_win ? 2'b10 : 2'b01;
               end
            end
            LATCH: begin
               r_b   <= r_w ? a1 : a0;
               r_opr <= op[r_w];
            end
            EXEC: begin
               r_s     <= w_s_next;
               r_carry <= w_res[N];
               r_ovf   <= w_ovf;
               r_last  <= r_w;
               r_ack   <= r_w ? 2'b10 : 2'b01;
            end
            DONE: begin
               r_ack <= 2'b00;
               r_gnt <= 2'b00;
            end
            default: begin
               r_ack <= 2'b00;
               r_gnt <= 2'b00;
            end
         endcase
      end
   end

   assign gnt      = r_gnt;
   assign ack      = r_ack;
   assign busy     = w_busy;
   assign S        = r_s;
   assign carry    = r_carry;
   assign overflow = r_ovf;
   assign last_id  = r_last;

endmodule
